// File: rtl/subckt_eval_sched.sv
// Round-robin scheduler in front of one shared, pipelined evaluator of
// f(v) = v[1] ^ (v[3] & ~v[2] & ~v[0]), with a built-in 16-entry truth-table sweep.
module subckt_eval_sched #(
   parameter int EVAL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req_valid,
   input  logic [15:0] req_vec,
   output logic [3:0]  req_ready,
   output logic        rsp_valid,
   output logic [1:0]  rsp_id,
   output logic        rsp_bit,
   input  logic        sweep_start,
   output logic        sweep_busy,
   output logic        sweep_done,
   output logic [15:0] sweep_table
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SWEEP = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   function automatic logic eval_f(input logic [3:0] v);
      return v[1] ^ (v[3] & ~v[2] & ~v[0]);
   endfunction

   logic [1:0]  state_reg;
   logic [1:0]  ptr_reg;
   logic [3:0]  pat_reg;
   logic        done_reg;
   logic [15:0] table_reg;

   logic        grant_found;
   logic [1:0]  grant_id;
   logic [1:0]  cand;
   logic        sweep_accept;

   logic        in_valid;
   logic        in_tag;
   logic [1:0]  in_id;
   logic [3:0]  in_vec;

   logic        ent_valid;
   logic        ent_tag;
   logic [3:0]  ent_vec;
   logic        ent_bit;
   logic        last_write;

   // Arbiter is gated by reset and by a pending sweep request so a colliding sweep wins.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = ptr_reg;
      cand        = 2'd0;
      req_ready   = 4'd0;
      if (rst_n && state_reg == IDLE && !sweep_start) begin
         for (int j = 0; j < 4; j++) begin
            cand = ptr_reg + 2'(j);
            if (!grant_found && req_valid[cand]) begin
               grant_found = 1'b1;
               grant_id    = cand;
            end
         end
         if (grant_found) begin
            req_ready[grant_id] = 1'b1;
         end
      end
   end

   assign sweep_accept = (state_reg == IDLE) && sweep_start;

   assign in_valid = grant_found || (state_reg == SWEEP);
   assign in_tag   = (state_reg == SWEEP);
   assign in_id    = grant_id;
   assign in_vec   = (state_reg == SWEEP) ? pat_reg : req_vec[{grant_id, 2'b00} +: 4];

   // Stage gi holds a vector accepted gi edges ago; the last stage is the user result.
   genvar gi;
   generate
      for (gi = 0; gi < EVAL_LAT; gi++) begin : g_stage
         logic       valid_reg;
         logic       tag_reg;
         logic [1:0] id_reg;
         logic       bit_reg;

         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  valid_reg <= 1'b0;
               end else begin
                  valid_reg <= in_valid;
               end
            end
            always_ff @(posedge clk) begin
               tag_reg <= in_tag;
               id_reg  <= in_id;
               bit_reg <= eval_f(in_vec);
            end
         end else begin : g_body
            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  valid_reg <= 1'b0;
               end else begin
                  valid_reg <= g_stage[gi-1].valid_reg;
               end
            end
            always_ff @(posedge clk) begin
               tag_reg <= g_stage[gi-1].tag_reg;
               id_reg  <= g_stage[gi-1].id_reg;
               bit_reg <= g_stage[gi-1].bit_reg;
            end
         end

         // The pattern index is only needed up to the entry of the final stage.
         if (gi < EVAL_LAT - 1) begin : g_vec
            logic [3:0] vec_reg;
            if (gi == 0) begin : g_vhead
               always_ff @(posedge clk) begin
                  vec_reg <= in_vec;
               end
            end else begin : g_vbody
               always_ff @(posedge clk) begin
                  vec_reg <= g_stage[gi-1].g_vec.vec_reg;
               end
            end
         end
      end

      if (EVAL_LAT == 1) begin : g_ent_direct
         assign ent_valid = in_valid;
         assign ent_tag   = in_tag;
         assign ent_vec   = in_vec;
         assign ent_bit   = eval_f(in_vec);
      end else begin : g_ent_stage
         assign ent_valid = g_stage[EVAL_LAT-2].valid_reg;
         assign ent_tag   = g_stage[EVAL_LAT-2].tag_reg;
         assign ent_vec   = g_stage[EVAL_LAT-2].g_vec.vec_reg;
         assign ent_bit   = g_stage[EVAL_LAT-2].bit_reg;
      end
   endgenerate

   // Sweep results land in the table on the same edge a user result would become visible.
   assign last_write = ent_valid && ent_tag && (ent_vec == 4'hF);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         table_reg <= 16'd0;
      end else if (sweep_accept) begin
         table_reg <= 16'd0;
      end else if (ent_valid && ent_tag) begin
         table_reg[ent_vec] <= ent_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         ptr_reg   <= 2'd0;
         pat_reg   <= 4'd0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (sweep_start) begin
                  state_reg <= SWEEP;
                  pat_reg   <= 4'd0;
               end else if (grant_found) begin
                  ptr_reg <= grant_id + 2'd1;
               end
            end
            SWEEP: begin
               pat_reg <= pat_reg + 4'd1;
               if (last_write) begin
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
               end else if (pat_reg == 4'hF) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_write) begin
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign rsp_valid   = g_stage[EVAL_LAT-1].valid_reg & ~g_stage[EVAL_LAT-1].tag_reg;
   assign rsp_id      = g_stage[EVAL_LAT-1].id_reg;
   assign rsp_bit     = g_stage[EVAL_LAT-1].bit_reg;
   assign sweep_busy  = (state_reg != IDLE);
   assign sweep_done  = done_reg;
   assign sweep_table = table_reg;

endmodule

// File: tb/tb_subckt_eval_sched.sv
// Directed bench for subckt_eval_sched (EVAL_LAT=2): single request, contention,
// sweep with collision and in-flight overlap, and reset in the middle of a sweep.
module tb_subckt_eval_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_vec;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic        rsp_bit;
   logic        sweep_start;
   logic        sweep_busy;
   logic        sweep_done;
   logic [15:0] sweep_table;

   int n_tests = 0;
   int n_fail  = 0;

   subckt_eval_sched #(.EVAL_LAT(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_vec     (req_vec),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_bit     (rsp_bit),
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done),
      .sweep_table (sweep_table)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected bits for contention vectors 0x2,0xA,0x0,0xF
   logic [3:0] exp_bits;

   initial begin
      exp_bits    = 4'b1001;
      rst_n       = 1'b0;
      req_valid   = 4'b1111;
      req_vec     = 16'h0;
      sweep_start = 1'b0;
      #1;
      check("ready_in_reset", {28'd0, req_ready}, 32'h0);
      step();
      step();
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'h0);
      check("rst_busy", {31'd0, sweep_busy}, 32'h0);
      check("rst_done", {31'd0, sweep_done}, 32'h0);
      check("rst_table", {16'd0, sweep_table}, 32'h0);

      // Single request: vec0=0x8 -> bit 1
      rst_n     = 1'b1;
      req_valid = 4'b0001;
      req_vec   = 16'h0008;
      #1;
      check("single_ready", {28'd0, req_ready}, 32'h1);
      step();
      req_valid = 4'b0000;
      check("single_lat_early", {31'd0, rsp_valid}, 32'h0);
      step();
      check("single_rsp_valid", {31'd0, rsp_valid}, 32'h1);
      check("single_rsp_id", {30'd0, rsp_id}, 32'h0);
      check("single_rsp_bit", {31'd0, rsp_bit}, 32'h1);
      step();
      check("single_rsp_once", {31'd0, rsp_valid}, 32'h0);

      // Contention from a fresh pointer
      rst_n = 1'b0;
      step();
      rst_n     = 1'b1;
      req_vec   = 16'hF0A2;
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("cont_ready_%0d", i), {28'd0, req_ready}, 32'(4'b0001 << (i % 4)));
         step();
         if (i >= 1) begin
            check($sformatf("cont_rsp_valid_%0d", i), {31'd0, rsp_valid}, 32'h1);
            check($sformatf("cont_rsp_id_%0d", i), {30'd0, rsp_id}, 32'((i - 1) % 4));
            check($sformatf("cont_rsp_bit_%0d", i), {31'd0, rsp_bit}, {31'd0, exp_bits[(i - 1) % 4]});
         end
      end
      req_valid = 4'b0000;
      step();
      check("cont_last_valid", {31'd0, rsp_valid}, 32'h1);
      check("cont_last_id", {30'd0, rsp_id}, 32'h3);
      check("cont_last_bit", {31'd0, rsp_bit}, 32'h1);
      step();

      // In-flight user request one edge before a colliding sweep_start (p=0 -> grants 0, p becomes 1)
      req_valid = 4'b0001;
      step();
      sweep_start = 1'b1;
      req_valid   = 4'b1111;
      #1;
      check("collide_ready", {28'd0, req_ready}, 32'h0);
      step();
      sweep_start = 1'b0;
      check("sweep_busy_t", {31'd0, sweep_busy}, 32'h1);
      check("inflight_valid", {31'd0, rsp_valid}, 32'h1);
      check("inflight_id", {30'd0, rsp_id}, 32'h0);
      check("inflight_bit", {31'd0, rsp_bit}, 32'h1);
      for (int j = 1; j <= 17; j++) begin
         sweep_start = (j == 5);
         #1;
         check($sformatf("sweep_ready_%0d", j), {28'd0, req_ready}, 32'h0);
         step();
         sweep_start = 1'b0;
         check($sformatf("sweep_norsp_%0d", j), {31'd0, rsp_valid}, 32'h0);
         if (j < 17) begin
            check($sformatf("sweep_busy_%0d", j), {31'd0, sweep_busy}, 32'h1);
            check($sformatf("sweep_nodone_%0d", j), {31'd0, sweep_done}, 32'h0);
         end
      end
      check("sweep_done", {31'd0, sweep_done}, 32'h1);
      check("sweep_idle", {31'd0, sweep_busy}, 32'h0);
      check("sweep_table", {16'd0, sweep_table}, 32'hC9CC);
      #1;
      check("resume_ready_p1", {28'd0, req_ready}, 32'h2);
      step();
      req_valid = 4'b0000;
      check("done_one_cycle", {31'd0, sweep_done}, 32'h0);
      check("table_hold", {16'd0, sweep_table}, 32'hC9CC);
      step();
      check("resume_rsp_valid", {31'd0, rsp_valid}, 32'h1);
      check("resume_rsp_id", {30'd0, rsp_id}, 32'h1);
      check("resume_rsp_bit", {31'd0, rsp_bit}, 32'h0);
      step();

      // Reset while pattern 7 is being issued
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      for (int j = 1; j <= 7; j++) step();
      check("partial_table", {16'd0, sweep_table}, 32'h000C);
      rst_n = 1'b0;
      step();
      check("midrst_busy", {31'd0, sweep_busy}, 32'h0);
      check("midrst_table", {16'd0, sweep_table}, 32'h0);
      check("midrst_rsp", {31'd0, rsp_valid}, 32'h0);
      check("midrst_done", {31'd0, sweep_done}, 32'h0);
      rst_n     = 1'b1;
      req_valid = 4'b0001;
      req_vec   = 16'h0008;
      #1;
      check("post_ready", {28'd0, req_ready}, 32'h1);
      step();
      req_valid = 4'b0000;
      check("post_lat_early", {31'd0, rsp_valid}, 32'h0);
      check("post_nodone", {31'd0, sweep_done}, 32'h0);
      step();
      check("post_rsp_valid", {31'd0, rsp_valid}, 32'h1);
      check("post_rsp_id", {30'd0, rsp_id}, 32'h0);
      check("post_rsp_bit", {31'd0, rsp_bit}, 32'h1);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/subckt_eval_sched.md
SUBCKT_EVAL_SCHED -- requirements
Module: subckt_eval_sched

Interface
REQ-001 The block SHALL have parameter EVAL_LAT, default 2, meaning the pipeline depth of the shared evaluator in cycles (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 4 bits: one request-valid bit per requester 0..3.
REQ-005 The block SHALL have port req_vec, input, 16 bits: the 4-bit input vector of requester i at req_vec[4i+3:4i], ordered {n_4,n_3,n_2,n_1}.
REQ-006 The block SHALL have port req_ready, output, 4 bits: grant/accept strobe, one-hot or zero.
REQ-007 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle result strobe.
REQ-008 The block SHALL have port rsp_id, output, 2 bits: the requester index of the result.
REQ-009 The block SHALL have port rsp_bit, output, 1 bit: the evaluated function value.
REQ-010 The block SHALL have port sweep_start, input, 1 bit: a request for a truth-table sweep.
REQ-011 The block SHALL have port sweep_busy, output, 1 bit: high in SWEEP and DRAIN.
REQ-012 The block SHALL have port sweep_done, output, 1 bit: a one-cycle pulse at sweep completion.
REQ-013 The block SHALL have port sweep_table, output, 16 bits: bit k holds f(k) from the last sweep.

Function
REQ-014 The evaluator SHALL compute f(v) = v[1] XOR (v[3] AND NOT v[2] AND NOT v[0]), where v = {n_4,n_3,n_2,n_1}; the expected full table is 0xC9CC.
REQ-015 The evaluator SHALL be a single shared pipeline that accepts at most one vector per cycle, with a 1-bit source tag (user/sweep) plus a 2-bit id carried alongside each vector.
REQ-016 The FSM SHALL have states IDLE, SWEEP and DRAIN; reset state IDLE.
REQ-017 In IDLE, the arbiter SHALL be round-robin: it grants the first requester with req_valid set, searching from pointer p upward with wrap from 3 to 0; p resets to 0 and becomes granted+1 mod 4 after each grant.
REQ-018 req_ready SHALL be combinational from req_valid and p, asserted only in IDLE and only when sweep_start is low; a transfer occurs when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-019 A vector accepted at edge k SHALL produce rsp_valid=1 with its rsp_id and rsp_bit for exactly the cycle following edge k+EVAL_LAT-1; there is no response backpressure.
REQ-020 rsp_id and rsp_bit SHALL be don't-care when rsp_valid=0.
REQ-021 sweep_start sampled high in IDLE SHALL: clear sweep_table, enter SWEEP and take priority over any simultaneous req_valid, so no grant occurs that cycle.
REQ-022 sweep_start SHALL be ignored in SWEEP and DRAIN.
REQ-023 SWEEP SHALL issue patterns 0..15, one per cycle on 16 consecutive edges, then enter DRAIN.
REQ-024 When each sweep-tagged result exits the pipeline, the block SHALL write it to sweep_table[pattern] and SHALL NOT assert rsp_valid for it.
REQ-025 DRAIN SHALL exit to IDLE when pattern 15's result is written; sweep_done SHALL be high for exactly the following cycle.
REQ-026 sweep_table SHALL hold its value until the next accepted sweep_start.
REQ-027 req_ready SHALL be 0 throughout SWEEP and DRAIN.
REQ-028 User vectors already in flight when a sweep starts SHALL still emerge with rsp_valid at their normal latency.

Reset
REQ-029 While rst_n=0 at an edge, the block SHALL set the following, all effective in the next cycle: state IDLE, p=0, all pipeline stages invalid, in-flight results dropped, sweep_table=0, and rsp_valid, sweep_busy and sweep_done all 0.
REQ-030 req_ready SHALL be 0 during any cycle in which rst_n=0.

Verification
REQ-031 Single request: req_valid=0001, vec0=0x8 accepted at edge k -> rsp_valid in the cycle after edge k+1 (EVAL_LAT=2), rsp_id=0, rsp_bit=1.
REQ-032 Contention: all four valid continuously with vecs 0x2,0xA,0x0,0xF -> grants 0,1,2,3,0,...; responses return in that order with bits 1,0,0,1.
REQ-033 Sweep: sweep_start at edge t from IDLE -> sweep_busy=1 from t; sweep_done pulses in the cycle after edge t+17; sweep_table=0xC9CC; no rsp_valid is produced by the sweep.
REQ-034 Collision: sweep_start and req_valid=1111 at the same edge -> no req_ready that cycle, nor until IDLE resumes; the arbiter then grants starting from the unchanged p.
REQ-035 In-flight overlap: a user request is accepted one edge before sweep_start -> its response is still delivered with the correct id and bit; a second sweep_start during SWEEP is ignored.
REQ-036 Reset mid-sweep: rst_n=0 at pattern 7 -> the next cycle shows sweep_busy=0, sweep_table=0 and no rsp_valid or sweep_done, and a fresh request behaves as in REQ-031.
